seq_clk_ctrl: RTL and testbench
===============================

// Module: seq_clk_ctrl
// PURPOSE
//  Sequences the modulation-free sequence clock: arms on SEQ_CLK_INIT, starts on SYNC, divides
//  REF_CLK_TICK by SEQ_CLK_DIV and steps a wrap-around sequence index modulo SEQ_CLK_CYCLE.
//  Sits between the config/sync master and the point/gain sequence memories; consumes the
//  seq_sync_if slave-side signals and drives the read index plus an update strobe.
// PARAMETERS
//  IDX_W           16  width of SEQ_IDX and SEQ_CLK_CYCLE
//  DIV_W           16  width of SEQ_CLK_DIV and the internal divider counter
//  RESYNC_ON_SYNC  1   1: SYNC while RUN restarts index/divider; 0: SYNC ignored while RUN
// PORTS
//  CLK             in   1      system clock
//  RST_N           in   1      asynchronous reset, active low
//  SEQ_CLK_CYCLE   in   IDX_W  sequence length in steps (0 treated as 1)
//  SEQ_CLK_DIV     in   DIV_W  ticks per step (0 treated as 1)
//  SEQ_CLK_INIT    in   1      level; rising edge arms the controller
//  REF_CLK_TICK    in   1      one-cycle reference tick
//  SYNC            in   1      one-cycle global sync pulse
//  OP_MODE         in   1      1 = sequence mode enabled, 0 = normal (controller idle)
//  SEQ_MODE        in   1      0 = point sequence, 1 = gain sequence
//  SEQ_IDX         out  IDX_W  current sequence index
//  SEQ_IDX_UPDATE  out  1      one-cycle pulse in the cycle SEQ_IDX takes a new value
//  SEQ_RUN         out  1      1 while state == RUN
//  SEQ_MODE_Q      out  1      SEQ_MODE latched at ARMED->RUN
// BEHAVIOUR
//  - Reset (RST_N=0, async): state IDLE; SEQ_IDX=0, div_cnt=0, SEQ_IDX_UPDATE=0, SEQ_RUN=0,
//    SEQ_MODE_Q=0, init_q=0. All outputs registered.
//  - init_rise = SEQ_CLK_INIT & ~init_q; init_q registered every cycle.
//  - eff_div = (DIV==0)?1:DIV; eff_cyc = (CYCLE==0)?1:CYCLE.
//  - States: IDLE, ARMED, RUN. Priority each cycle: OP_MODE=0 > init_rise > SYNC > tick.
//    IDLE : OP_MODE & init_rise -> ARMED.
//    ARMED: SYNC -> RUN; SEQ_IDX<=0, div_cnt<=0, SEQ_MODE_Q<=SEQ_MODE, SEQ_IDX_UPDATE<=1.
//           A tick in ARMED is ignored.
//    RUN  : SYNC & RESYNC_ON_SYNC -> same as ARMED->RUN entry (SYNC beats a coincident tick).
//           tick: if div_cnt>=eff_div-1 {div_cnt<=0; SEQ_IDX<=(SEQ_IDX>=eff_cyc-1)?0:SEQ_IDX+1;
//           SEQ_IDX_UPDATE<=1} else div_cnt<=div_cnt+1.
//    Any state: OP_MODE=0 -> IDLE next cycle, SEQ_IDX=0, div_cnt=0, SEQ_RUN=0.
//    ARMED/RUN: init_rise -> ARMED, index and divider cleared, SEQ_RUN=0.
//  - Latency: tick/SYNC sampled at edge n -> SEQ_IDX/SEQ_IDX_UPDATE valid after edge n (1 cycle).
//  - SEQ_IDX_UPDATE high exactly one cycle per index change or restart; 0 otherwise.
//  - ">=" comparisons make a shrunken CYCLE/DIV wrap on the next step, never overrun.
//  - All arithmetic unsigned; div_cnt and SEQ_IDX never exceed their width (no overflow path).
// CONFIGURATION
//  SEQ_CLK_SHADOW_EN defined: CYCLE/DIV copied into shadow regs on RUN entry and at each index
//    wrap to 0; eff_div/eff_cyc use shadow values, mid-sequence changes apply from next period.
//  Undefined: CYCLE/DIV used live every cycle; no shadow registers.
// STRUCTURE
//  seq_ctrl_pkg: typedef enum logic[1:0] {IDLE,ARMED,RUN} seq_state_t; default IDX_W/DIV_W.
//  Sub-module seq_tick_div: tick divider (div_cnt, eff_div, step pulse out); FSM/index in top.
// TESTING
//  1 Reset mid-RUN (SEQ_IDX=5): RST_N low -> all outputs 0 same cycle, state IDLE.
//  2 OP_MODE=1, init rise, SYNC, CYCLE=4, DIV=3, tick every cycle -> SEQ_IDX 0,1,2,3,0
//    changing every 3 ticks; SEQ_IDX_UPDATE pulses once per change.
//  3 DIV=0, CYCLE=0 -> eff 1/1: SEQ_IDX stays 0, UPDATE pulses every tick.
//  4 RUN at SEQ_IDX=3, SYNC and tick same cycle -> SEQ_IDX=0, div_cnt=0 (RESYNC_ON_SYNC=1);
//    with RESYNC_ON_SYNC=0 -> normal tick step only.
//  5 RUN at SEQ_IDX=7, CYCLE changed 10->5 -> next step SEQ_IDX=0 (no shadow);
//    with SEQ_CLK_SHADOW_EN -> continues 8,9,0 then period 5.
//  6 OP_MODE dropped in RUN -> next cycle IDLE, SEQ_RUN=0; SYNC alone does not restart
//    until a new init rise.

Source files
------------

// File: rtl/seq_ctrl_pkg.sv
// Shared types and default widths for the sequence clock controller.
package seq_ctrl_pkg;

  localparam int SEQ_IDX_W_DEF = 16;
  localparam int SEQ_DIV_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } seq_state_t;

endpackage

// File: rtl/seq_tick_div.sv
// Reference-tick divider: counts enabled ticks and emits a step pulse every eff_div ticks.
module seq_tick_div #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             tick_en,
  input  logic [DIV_W-1:0] div_val,
  output logic             step
);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;
  logic [DIV_W-1:0] eff_div;

  assign eff_div = (div_val == '0) ? DIV_W'(1) : div_val;

  // ">=" lets a divisor that shrank below the current count wrap on the next tick.
  always_comb begin
    div_cnt_d = div_cnt_q;
    step      = 1'b0;
    if (clear) begin
      div_cnt_d = '0;
    end else if (tick_en) begin
      if (div_cnt_q >= eff_div - DIV_W'(1)) begin
        div_cnt_d = '0;
        step      = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/seq_clk_ctrl.sv
// Sequence clock controller: IDLE -> ARMED on init rise, RUN on SYNC, steps index per divided tick.
// Optional SEQ_CLK_SHADOW_EN: CYCLE/DIV sampled on RUN entry and at each index wrap.
module seq_clk_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int   IDX_W          = SEQ_IDX_W_DEF,
  parameter int   DIV_W          = SEQ_DIV_W_DEF,
  parameter logic RESYNC_ON_SYNC = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [IDX_W-1:0] SEQ_CLK_CYCLE,
  input  logic [DIV_W-1:0] SEQ_CLK_DIV,
  input  logic             SEQ_CLK_INIT,
  input  logic             REF_CLK_TICK,
  input  logic             SYNC,
  input  logic             OP_MODE,
  input  logic             SEQ_MODE,
  output logic [IDX_W-1:0] SEQ_IDX,
  output logic             SEQ_IDX_UPDATE,
  output logic             SEQ_RUN,
  output logic             SEQ_MODE_Q
);

  seq_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             upd_q, upd_d;
  logic             run_q, run_d;
  logic             mode_q, mode_d;
  logic             init_q;

  logic             init_rise;
  logic             restart;
  logic             div_clear;
  logic             tick_en;
  logic             step;
  logic             wrap;
  logic [IDX_W-1:0] cyc_src;
  logic [DIV_W-1:0] div_src;
  logic [IDX_W-1:0] eff_cyc;

  assign init_rise = SEQ_CLK_INIT & ~init_q;

  // Priority chain: OP_MODE low, then init rise, then SYNC, then tick.
  assign restart   = OP_MODE & ~init_rise & SYNC &
                     ((state_q == ARMED) | ((state_q == RUN) & RESYNC_ON_SYNC));
  assign div_clear = ~OP_MODE | init_rise | restart;
  assign tick_en   = OP_MODE & ~init_rise & ~restart & (state_q == RUN) & REF_CLK_TICK;

  assign eff_cyc   = (cyc_src == '0) ? IDX_W'(1) : cyc_src;
  assign wrap      = step & (idx_q >= eff_cyc - IDX_W'(1));

`ifdef SEQ_CLK_SHADOW_EN
  logic [IDX_W-1:0] cyc_sh_q, cyc_sh_d;
  logic [DIV_W-1:0] div_sh_q, div_sh_d;

  always_comb begin
    cyc_sh_d = cyc_sh_q;
    div_sh_d = div_sh_q;
    if (restart | wrap) begin
      cyc_sh_d = SEQ_CLK_CYCLE;
      div_sh_d = SEQ_CLK_DIV;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cyc_sh_q <= '0;
      div_sh_q <= '0;
    end else begin
      cyc_sh_q <= cyc_sh_d;
      div_sh_q <= div_sh_d;
    end
  end

  assign cyc_src = cyc_sh_q;
  assign div_src = div_sh_q;
`else
  assign cyc_src = SEQ_CLK_CYCLE;
  assign div_src = SEQ_CLK_DIV;
`endif

  seq_tick_div #(
    .DIV_W (DIV_W)
  ) u_tick_div (
    .clk     (CLK),
    .rst_n   (RST_N),
    .clear   (div_clear),
    .tick_en (tick_en),
    .div_val (div_src),
    .step    (step)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    upd_d   = 1'b0;
    mode_d  = mode_q;
    if (!OP_MODE) begin
      state_d = IDLE;
      idx_d   = '0;
    end else if (init_rise) begin
      state_d = ARMED;
      idx_d   = '0;
    end else if (restart) begin
      state_d = RUN;
      idx_d   = '0;
      mode_d  = SEQ_MODE;
      upd_d   = 1'b1;
    end else if (step) begin
      idx_d = wrap ? '0 : idx_q + IDX_W'(1);
      upd_d = 1'b1;
    end
    run_d = (state_d == RUN);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      idx_q   <= '0;
      upd_q   <= 1'b0;
      run_q   <= 1'b0;
      mode_q  <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      upd_q   <= upd_d;
      run_q   <= run_d;
      mode_q  <= mode_d;
      init_q  <= SEQ_CLK_INIT;
    end
  end

  assign SEQ_IDX        = idx_q;
  assign SEQ_IDX_UPDATE = upd_q;
  assign SEQ_RUN        = run_q;
  assign SEQ_MODE_Q     = mode_q;

endmodule

// File: tb/tb_seq_clk_ctrl.sv
// Directed bench for seq_clk_ctrl; a second instance runs with SYNC-resync disabled.
module tb_seq_clk_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] cyc;
  logic [15:0] div;
  logic        init;
  logic        tick;
  logic        sync;
  logic        op_mode;
  logic        seq_mode;

  logic [15:0] idx, idx_nr;
  logic        upd, upd_nr;
  logic        run, run_nr;
  logic        mode_q, mode_q_nr;

  int n_cmp = 0;
  int n_err = 0;

  int exp_tail[7];

  seq_clk_ctrl dut (
    .CLK            (clk),
    .RST_N          (rst_n),
    .SEQ_CLK_CYCLE  (cyc),
    .SEQ_CLK_DIV    (div),
    .SEQ_CLK_INIT   (init),
    .REF_CLK_TICK   (tick),
    .SYNC           (sync),
    .OP_MODE        (op_mode),
    .SEQ_MODE       (seq_mode),
    .SEQ_IDX        (idx),
    .SEQ_IDX_UPDATE (upd),
    .SEQ_RUN        (run),
    .SEQ_MODE_Q     (mode_q)
  );

  seq_clk_ctrl #(.RESYNC_ON_SYNC(1'b0)) dut_nr (
    .CLK            (clk),
    .RST_N          (rst_n),
    .SEQ_CLK_CYCLE  (cyc),
    .SEQ_CLK_DIV    (div),
    .SEQ_CLK_INIT   (init),
    .REF_CLK_TICK   (tick),
    .SYNC           (sync),
    .OP_MODE        (op_mode),
    .SEQ_MODE       (seq_mode),
    .SEQ_IDX        (idx_nr),
    .SEQ_IDX_UPDATE (upd_nr),
    .SEQ_RUN        (run_nr),
    .SEQ_MODE_Q     (mode_q_nr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of control inputs, then settle just past the sampling edge.
  task automatic applyStimulus(input logic i_init, input logic i_sync, input logic i_tick);
    init = i_init;
    sync = i_sync;
    tick = i_tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef SEQ_CLK_SHADOW_EN
    exp_tail = '{8, 9, 0, 1, 2, 3, 4};
`else
    exp_tail = '{0, 1, 2, 3, 4, 0, 1};
`endif
    rst_n    = 1'b0;
    cyc      = 16'd4;
    div      = 16'd3;
    init     = 1'b0;
    tick     = 1'b0;
    sync     = 1'b0;
    op_mode  = 1'b0;
    seq_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_idx", idx, 0);
    checkOutput("reset_upd", upd, 0);
    checkOutput("reset_run", run, 0);
    checkOutput("reset_mode_q", mode_q, 0);
    rst_n = 1'b1;

    // Basic sequence: CYCLE=4, DIV=3, tick every cycle.
    op_mode  = 1'b1;
    seq_mode = 1'b1;
    applyStimulus(1, 0, 0);
    checkOutput("armed_run", run, 0);
    checkOutput("armed_upd", upd, 0);
    applyStimulus(1, 1, 0);
    checkOutput("start_run", run, 1);
    checkOutput("start_idx", idx, 0);
    checkOutput("start_upd", upd, 1);
    checkOutput("start_mode_q", mode_q, 1);
    checkOutput("start_run_nr", run_nr, 1);
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1, 0, 1);
      checkOutput("seq_idx", idx, (k / 3) % 4);
      checkOutput("seq_upd", upd, (k % 3 == 0) ? 1 : 0);
      checkOutput("seq_idx_nr", idx_nr, (k / 3) % 4);
    end

    // SYNC coincident with tick at index 3, DIV=2, CYCLE=8.
    cyc = 16'd8;
    div = 16'd2;
    repeat (6) applyStimulus(1, 0, 1);
    checkOutput("pre_sync_idx", idx, 3);
    checkOutput("pre_sync_idx_nr", idx_nr, 3);
    applyStimulus(1, 0, 1);
    applyStimulus(1, 1, 1);
    checkOutput("resync_idx", idx, 0);
    checkOutput("resync_upd", upd, 1);
    checkOutput("noresync_idx", idx_nr, 4);
    checkOutput("noresync_upd", upd_nr, 1);
    applyStimulus(1, 0, 1);
    checkOutput("resync_cnt_idx", idx, 0);
    checkOutput("resync_cnt_upd", upd, 0);
    checkOutput("noresync_cnt_idx", idx_nr, 4);
    applyStimulus(1, 0, 1);
    checkOutput("resync_step_idx", idx, 1);
    checkOutput("noresync_step_idx", idx_nr, 5);

    // DIV=0 and CYCLE=0 behave as 1/1.
    cyc = 16'd0;
    div = 16'd0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 1);
      checkOutput("zero_idx", idx, 0);
      checkOutput("zero_upd", upd, 1);
    end
    applyStimulus(1, 0, 0);
    checkOutput("zero_notick_upd", upd, 0);

    // CYCLE shrinks 10 -> 5 while at index 7.
    cyc = 16'd10;
    div = 16'd1;
    applyStimulus(1, 1, 0);
    checkOutput("shrink_restart_idx", idx, 0);
    repeat (7) applyStimulus(1, 0, 1);
    checkOutput("shrink_pre_idx", idx, 7);
    cyc = 16'd5;
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1, 0, 1);
      checkOutput("shrink_idx", idx, exp_tail[k]);
    end

    // A new init rise while running re-arms; ticks in ARMED are ignored.
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 0);
    checkOutput("rearm_run", run, 0);
    checkOutput("rearm_idx", idx, 0);
    applyStimulus(1, 0, 1);
    checkOutput("armed_tick_idx", idx, 0);
    checkOutput("armed_tick_upd", upd, 0);
    applyStimulus(1, 1, 0);
    checkOutput("rearm_start_run", run, 1);
    checkOutput("rearm_start_upd", upd, 1);

    // Dropping OP_MODE returns to IDLE; SYNC alone cannot restart.
    repeat (2) applyStimulus(1, 0, 1);
    checkOutput("opm_pre_idx", idx, 2);
    op_mode = 1'b0;
    applyStimulus(1, 0, 0);
    checkOutput("opm_off_run", run, 0);
    checkOutput("opm_off_idx", idx, 0);
    op_mode = 1'b1;
    applyStimulus(1, 1, 0);
    checkOutput("opm_sync_run", run, 0);
    checkOutput("opm_sync_upd", upd, 0);
    applyStimulus(1, 1, 1);
    checkOutput("opm_sync_tick_run", run, 0);
    applyStimulus(0, 0, 0);
    seq_mode = 1'b0;
    applyStimulus(1, 0, 0);
    checkOutput("opm_arm_run", run, 0);
    applyStimulus(1, 1, 0);
    checkOutput("opm_restart_run", run, 1);
    checkOutput("opm_restart_upd", upd, 1);
    checkOutput("opm_restart_mode_q", mode_q, 0);

    // Asynchronous reset mid-RUN at index 5.
    cyc = 16'd10;
    div = 16'd1;
    repeat (5) applyStimulus(1, 0, 1);
    checkOutput("mid_pre_idx", idx, 5);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_idx", idx, 0);
    checkOutput("mid_reset_upd", upd, 0);
    checkOutput("mid_reset_run", run, 0);
    checkOutput("mid_reset_mode_q", mode_q, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 1, 0);
    checkOutput("post_reset_sync_run", run, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
